// File: rtl/scr1_apb_timer_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : scr1_apb_timer_bridge_pkg                                        |
// | Brief   : SCR1 dmem-style memory interface codes shared by bridge users.   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package scr1_apb_timer_bridge_pkg;

  typedef enum logic {
    MEMIF_CMD_RD = 1'b0,
    MEMIF_CMD_WR = 1'b1
  } memif_cmd_e;

  localparam logic [1:0] MEMIF_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    MEMIF_RESP_IDLE  = 2'b00,
    MEMIF_RESP_OKAY  = 2'b01,
    MEMIF_RESP_ERROR = 2'b10
  } memif_resp_e;

endpackage
`default_nettype wire

// File: rtl/scr1_apb_timer_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : scr1_apb_timer_bridge                                             |
// | Brief  : APB3 slave to SCR1 dmem master bridge with response timeout.      |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module scr1_apb_timer_bridge
  import scr1_apb_timer_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ADDR_MASK      = 32'h0000_001F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        apb_psel,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [31:0] apb_paddr,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  output logic        apb_pready,
  output logic        apb_pslverr,
  output logic        dmem_req,
  output logic        dmem_cmd,
  output logic [1:0]  dmem_width,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_req_ack,
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  dmem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned          C_CNT_W    = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0]   C_CNT_MAX  = '1;

  state_e             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_abort;

  logic               w_timeout;
  logic               w_abort;
  logic               w_fin;
  logic               w_fin_err;
  logic [31:0]        w_fin_data;

  assign dmem_width = MEMIF_WIDTH_WORD;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == C_CNT_LAST);
  // Once the master lets go of psel the completion pulse must never appear.
  assign w_abort    = r_abort | ~apb_psel;

  always_comb begin
    w_fin      = 1'b0;
    w_fin_err  = 1'b0;
    w_fin_data = '0;
    case (r_state)
      ST_REQ: begin
        if (!dmem_req_ack && w_timeout) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      ST_RESP: begin
        if (dmem_resp == MEMIF_RESP_OKAY) begin
          w_fin      = 1'b1;
          w_fin_data = (dmem_cmd == MEMIF_CMD_WR) ? 32'h0 : dmem_rdata;
        end else if (dmem_resp == MEMIF_RESP_ERROR) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else if (w_timeout) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      default: begin
        w_fin = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_cmd    <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      apb_pready  <= 1'b0;
      apb_pslverr <= 1'b0;
      apb_prdata  <= '0;
    end else begin
      apb_pready  <= 1'b0;
      apb_pslverr <= 1'b0;
      apb_prdata  <= '0;

      if ((r_state == ST_REQ || r_state == ST_RESP) && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (apb_psel && !apb_penable) begin
            dmem_cmd   <= apb_pwrite;
            dmem_addr  <= apb_paddr & ADDR_MASK;
            dmem_wdata <= apb_pwdata;
            dmem_req   <= 1'b1;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_abort <= w_abort;
          if (dmem_req_ack) begin
            dmem_req <= 1'b0;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_abort <= w_abort;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_fin) begin
        dmem_req    <= 1'b0;
        r_state     <= ST_DONE;
        apb_pready  <= ~w_abort;
        apb_pslverr <= ~w_abort & w_fin_err;
        apb_prdata  <= w_abort ? 32'h0 : w_fin_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scr1_apb_timer_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_scr1_apb_timer_bridge                                          |
// | Brief  : Directed self-checking bench for the APB-to-dmem timer bridge.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_scr1_apb_timer_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
  logic        apb_pready, apb_pslverr;
  logic        dmem_req, dmem_cmd, dmem_req_ack;
  logic [1:0]  dmem_width, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  scr1_apb_timer_bridge #(
    .TIMEOUT_CYCLES (4),
    .ADDR_MASK      (32'h0000_001F)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apb_psel     (apb_psel),
    .apb_penable  (apb_penable),
    .apb_pwrite   (apb_pwrite),
    .apb_paddr    (apb_paddr),
    .apb_pwdata   (apb_pwdata),
    .apb_prdata   (apb_prdata),
    .apb_pready   (apb_pready),
    .apb_pslverr  (apb_pslverr),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp)
  );

  // Timer stub: mode 0 acks at once, 1 never acks, 2 acks on the 4th request cycle.
  int          stub_mode = 0;
  int          req_cycles;
  logic [1:0]  resp_q;
  logic [1:0]  force_resp = 2'b00;
  logic [31:0] rdata_q;
  logic [31:0] regs [0:7];

  assign dmem_req_ack = dmem_req && ((stub_mode == 0) || (stub_mode == 2 && req_cycles == 3));
  assign dmem_resp    = resp_q | force_resp;
  assign dmem_rdata   = rdata_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      req_cycles <= 0;
      resp_q     <= 2'b00;
      rdata_q    <= 32'h0;
      for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
      regs[0] <= 32'h0000_0001;
      regs[2] <= 32'h0000_1234;
      regs[4] <= 32'h5555_0000;
    end else begin
      req_cycles <= dmem_req ? req_cycles + 1 : 0;
      if (dmem_req && dmem_req_ack) begin
        if (dmem_addr[4:2] == 3'd7) begin
          resp_q  <= 2'b10;
          rdata_q <= 32'hBAD0_BAD0;
        end else begin
          resp_q  <= 2'b01;
          rdata_q <= regs[dmem_addr[4:2]];
          if (dmem_cmd) regs[dmem_addr[4:2]] <= dmem_wdata;
        end
      end else begin
        resp_q  <= 2'b00;
        rdata_q <= 32'hA5A5_A5A5;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int req_hi, output logic cmd_t1, output logic [31:0] addr_t1,
                          output logic [31:0] wdata_t1, output logic ready_after);
    int l, r;
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr; apb_paddr = addr; apb_pwdata = wdata;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    cmd_t1   = dmem_cmd;
    addr_t1  = dmem_addr;
    wdata_t1 = dmem_wdata;
    l = 1;
    r = dmem_req ? 1 : 0;
    while (!apb_pready && l < 20) begin
      @(posedge clk); #1;
      l++;
      if (dmem_req) r++;
    end
    rdata = apb_prdata;
    err   = apb_pslverr;
    @(posedge clk); #1;
    ready_after = apb_pready;
    apb_psel = 1'b0; apb_penable = 1'b0;
    lat    = l;
    req_hi = r;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a1, w1;
    logic        er, c1, ra;
    int          lat, rh, pcnt;
    logic        ack_seen;

    apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    apb_paddr = 32'h0; apb_pwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctrl", {28'h0, dmem_req, dmem_cmd, apb_pready, apb_pslverr}, 32'h0);
    check_eq("reset_prdata", apb_prdata, 32'h0);
    check_eq("reset_addr", dmem_addr, 32'h0);
    check_eq("reset_width", {30'h0, dmem_width}, 32'h2);
    rst_n = 1'b1;

    // 1. read mtime
    apb_xfer(1'b0, 32'h08, 32'h0, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("rd08_lat", lat, 3);
    check_eq("rd08_data", rd, 32'h0000_1234);
    check_eq("rd08_err", {31'h0, er}, 32'h0);
    check_eq("rd08_pulse", {31'h0, ra}, 32'h0);

    // 2. write with high address bits masked off, then read back
    apb_xfer(1'b1, 32'hFFFF_FF10, 32'hDEAD_BEEF, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("wr10_cmd", {31'h0, c1}, 32'h1);
    check_eq("wr10_addr", a1, 32'h10);
    check_eq("wr10_wdata", w1, 32'hDEAD_BEEF);
    check_eq("wr10_data", rd, 32'h0);
    check_eq("wr10_err", {31'h0, er}, 32'h0);
    check_eq("wr10_lat", lat, 3);
    apb_xfer(1'b0, 32'h10, 32'h0, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("rd10_cmd", {31'h0, c1}, 32'h0);
    check_eq("rd10_data", rd, 32'hDEAD_BEEF);
    check_eq("rd10_err", {31'h0, er}, 32'h0);

    // 3. invalid offset
    apb_xfer(1'b0, 32'h1C, 32'h0, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("rd1c_err", {31'h0, er}, 32'h1);
    check_eq("rd1c_data", rd, 32'h0);
    check_eq("rd1c_lat", lat, 3);

    // 4. silent target -> timeout, late response ignored
    stub_mode = 1;
    apb_xfer(1'b0, 32'h08, 32'h0, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("to_req_cycles", rh, 4);
    check_eq("to_lat", lat, 5);
    check_eq("to_err", {31'h0, er}, 32'h1);
    check_eq("to_data", rd, 32'h0);
    force_resp = 2'b01;
    pcnt = 0;
    @(posedge clk); #1;
    force_resp = 2'b00;
    if (apb_pready) pcnt++;
    repeat (3) begin
      @(posedge clk); #1;
      if (apb_pready) pcnt++;
    end
    check_eq("to_late_resp", pcnt, 0);

    // ack arriving on the timeout cycle wins
    stub_mode = 2;
    apb_xfer(1'b0, 32'h08, 32'h0, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("ackwin_lat", lat, 6);
    check_eq("ackwin_err", {31'h0, er}, 32'h0);
    check_eq("ackwin_data", rd, 32'h0000_1234);
    stub_mode = 0;

    // 5. reset in RESP
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 32'h08;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_pre_addr", dmem_addr, 32'h08);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_ctrl", {28'h0, dmem_req, dmem_cmd, apb_pready, apb_pslverr}, 32'h0);
    check_eq("rst_async_addr", dmem_addr, 32'h0);
    check_eq("rst_async_prdata", apb_prdata, 32'h0);
    apb_psel = 1'b0; apb_penable = 1'b0;
    pcnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (apb_pready) pcnt++;
    end
    check_eq("rst_no_ready", pcnt, 0);
    rst_n = 1'b1;
    apb_xfer(1'b0, 32'h00, 32'h0, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("rst_rd00_data", rd, 32'h1);
    check_eq("rst_rd00_lat", lat, 3);

    // reset in REQ drops dmem_req immediately
    stub_mode = 1;
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 32'h04;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    check_eq("rstreq_pre_req", {31'h0, dmem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstreq_req", {31'h0, dmem_req}, 32'h0);
    apb_psel = 1'b0; apb_penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stub_mode = 0;

    // 6. psel dropped in REQ: transaction completes silently
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 32'h08;
    @(posedge clk); #1;
    ack_seen = dmem_req_ack;
    apb_psel = 1'b0; apb_penable = 1'b0;
    pcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (apb_pready) pcnt++;
    end
    check_eq("abort_ack", {31'h0, ack_seen}, 32'h1);
    check_eq("abort_no_ready", pcnt, 0);
    apb_xfer(1'b0, 32'h08, 32'h0, rd, er, lat, rh, c1, a1, w1, ra);
    check_eq("abort_next_lat", lat, 3);
    check_eq("abort_next_data", rd, 32'h0000_1234);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
